// File: rtl/switch_arb_pkg.sv
// Shared types and helpers for the switch ingress arbiter.
package switch_arb_pkg;

  localparam int NUM_LANES = 4;

  typedef enum logic [0:0] {IDLE = 1'b0, DRIVE = 1'b1} arb_state_t;

  typedef logic [NUM_LANES-1:0] lane_vec_t;

  function automatic lane_vec_t onehot4(input logic [1:0] sel);
    return lane_vec_t'(4'b0001 << sel);
  endfunction

endpackage

// File: rtl/switch_ingress_arbiter_rr_pick4.sv
// Combinational round-robin picker: first eligible lane at or above ptr, wrapping 3 -> 0.
module rr_pick4
  import switch_arb_pkg::*;
(
  input  logic [3:0] eligible,
  input  logic [1:0] ptr,
  output logic [1:0] sel,
  output logic       any
);

  logic [3:0] rot_s;
  logic [1:0] off_s;

  // Rotate so bit 0 is the lane at ptr, then take the lowest set bit.
  always_comb begin
    rot_s = 4'({eligible, eligible} >> ptr);
    off_s = 2'd0;
    casez (rot_s)
      4'b???1: off_s = 2'd0;
      4'b??10: off_s = 2'd1;
      4'b?100: off_s = 2'd2;
      4'b1000: off_s = 2'd3;
      default: off_s = 2'd0;
    endcase
    sel = ptr + off_s;
    any = |eligible;
  end

endmodule

// File: rtl/switch_ingress_arbiter.sv
// Four-lane round-robin arbiter for the switch ingress bus with stall timeout.
// Optional per-lane grant/drop counters are enabled by SWITCH_ARB_GRANT_CNT_EN.
module switch_ingress_arbiter
  import switch_arb_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            req,
  input  logic [4*DATA_W-1:0]   req_data,
  input  logic [4*ADDR_W-1:0]   req_addr,
  output logic [3:0]            gnt,
  output logic [3:0]            drop,
  output logic [DATA_W-1:0]     data_in,
  output logic [ADDR_W-1:0]     addr_in,
  output logic [3:0]            valid_in,
  input  logic [3:0]            rcv_rdy,
  output logic                  busy
`ifdef SWITCH_ARB_GRANT_CNT_EN
  ,
  output logic [4*CNT_W-1:0]    grant_cnt,
  output logic [4*CNT_W-1:0]    drop_cnt
`endif
);

  localparam int WCNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit TO_EN  = (TIMEOUT != 0);
  localparam logic [WCNT_W-1:0] TO_LAST = WCNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  arb_state_t          state_q, state_d;
  logic [1:0]          rr_ptr_q, rr_ptr_d;
  logic [1:0]          sel_q, sel_d;
  logic [WCNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  lane_vec_t           gnt_q, gnt_d, drop_q, drop_d, valid_q, valid_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                busy_q, busy_d;

  lane_vec_t           eligible_s;
  logic [1:0]          pick_sel_s;
  logic                pick_any_s;

  // Lanes whose completion pulse is still visible must not be re-picked this cycle.
  assign eligible_s = req & ~gnt_q & ~drop_q;

  rr_pick4 u_pick (
    .eligible (eligible_s),
    .ptr      (rr_ptr_q),
    .sel      (pick_sel_s),
    .any      (pick_any_s)
  );

  // Next-state logic for the IDLE/DRIVE arbiter.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    sel_d      = sel_q;
    wait_cnt_d = wait_cnt_q;
    gnt_d      = 4'b0000;
    drop_d     = 4'b0000;
    valid_d    = valid_q;
    data_d     = data_q;
    addr_d     = addr_q;
    busy_d     = busy_q;
    case (state_q)
      IDLE: begin
        if (pick_any_s) begin
          data_d     = req_data[int'(pick_sel_s)*DATA_W +: DATA_W];
          addr_d     = req_addr[int'(pick_sel_s)*ADDR_W +: ADDR_W];
          valid_d    = onehot4(pick_sel_s);
          sel_d      = pick_sel_s;
          wait_cnt_d = {WCNT_W{1'b0}};
          state_d    = DRIVE;
          busy_d     = 1'b1;
        end else begin
          state_d    = IDLE;
          busy_d     = 1'b0;
        end
      end
      DRIVE: begin
        // Acceptance takes priority over a timeout landing on the same edge.
        if (rcv_rdy[sel_q]) begin
          valid_d  = 4'b0000;
          gnt_d    = onehot4(sel_q);
          rr_ptr_d = sel_q + 2'd1;
          state_d  = IDLE;
          busy_d   = 1'b0;
        end else if (TO_EN && (wait_cnt_q == TO_LAST)) begin
          valid_d  = 4'b0000;
          drop_d   = onehot4(sel_q);
          rr_ptr_d = sel_q + 2'd1;
          state_d  = IDLE;
          busy_d   = 1'b0;
        end else begin
          wait_cnt_d = wait_cnt_q + WCNT_W'(1'b1);
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 4'b0000;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= 2'd0;
      sel_q      <= 2'd0;
      wait_cnt_q <= {WCNT_W{1'b0}};
      gnt_q      <= 4'b0000;
      drop_q     <= 4'b0000;
      valid_q    <= 4'b0000;
      data_q     <= {DATA_W{1'b0}};
      addr_q     <= {ADDR_W{1'b0}};
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      sel_q      <= sel_d;
      wait_cnt_q <= wait_cnt_d;
      gnt_q      <= gnt_d;
      drop_q     <= drop_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
      busy_q     <= busy_d;
    end
  end

  assign gnt      = gnt_q;
  assign drop     = drop_q;
  assign valid_in = valid_q;
  assign data_in  = data_q;
  assign addr_in  = addr_q;
  assign busy     = busy_q;

`ifdef SWITCH_ARB_GRANT_CNT_EN
  for (genvar i = 0; i < 4; i++) begin : g_cnt
    logic [CNT_W-1:0] gcnt_q, dcnt_q;

    // Saturating per-lane counters, stepped by the registered pulses.
    always_ff @(posedge clk) begin
      if (reset) begin
        gcnt_q <= {CNT_W{1'b0}};
        dcnt_q <= {CNT_W{1'b0}};
      end else begin
        if (gnt_q[i] && (gcnt_q != {CNT_W{1'b1}})) begin
          gcnt_q <= gcnt_q + CNT_W'(1'b1);
        end else begin
          gcnt_q <= gcnt_q;
        end
        if (drop_q[i] && (dcnt_q != {CNT_W{1'b1}})) begin
          dcnt_q <= dcnt_q + CNT_W'(1'b1);
        end else begin
          dcnt_q <= dcnt_q;
        end
      end
    end

    assign grant_cnt[i*CNT_W +: CNT_W] = gcnt_q;
    assign drop_cnt[i*CNT_W +: CNT_W]  = dcnt_q;
  end
`endif

endmodule

// File: tb/tb_switch_ingress_arbiter.sv
// Directed self-checking bench; dut uses TIMEOUT=64, dut_t8 uses TIMEOUT=8 on the same stimulus.
module tb_switch_ingress_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req, rcv_rdy;
  logic [63:0] req_data, req_addr;

  logic [3:0]  gnt, drop, valid_in;
  logic [15:0] data_in, addr_in;
  logic        busy;
  logic [3:0]  t8_gnt, t8_drop, t8_valid_in;
  logic [15:0] t8_data_in, t8_addr_in;
  logic        t8_busy;
`ifdef SWITCH_ARB_GRANT_CNT_EN
  logic [15:0] grant_cnt, drop_cnt, t8_grant_cnt, t8_drop_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  switch_ingress_arbiter #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(64), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .req_addr(req_addr),
    .gnt(gnt), .drop(drop), .data_in(data_in), .addr_in(addr_in),
    .valid_in(valid_in), .rcv_rdy(rcv_rdy), .busy(busy)
`ifdef SWITCH_ARB_GRANT_CNT_EN
    , .grant_cnt(grant_cnt), .drop_cnt(drop_cnt)
`endif
  );

  switch_ingress_arbiter #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(8), .CNT_W(4)) dut_t8 (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .req_addr(req_addr),
    .gnt(t8_gnt), .drop(t8_drop), .data_in(t8_data_in), .addr_in(t8_addr_in),
    .valid_in(t8_valid_in), .rcv_rdy(rcv_rdy), .busy(t8_busy)
`ifdef SWITCH_ARB_GRANT_CNT_EN
    , .grant_cnt(t8_grant_cnt), .drop_cnt(t8_drop_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = 4'b0000; rcv_rdy = 4'b0000;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    req_data = 64'h1003_1002_1001_1000;
    req_addr = 64'h0033_0022_0011_0000;
    do_reset();
    n_tests++;
    if ({valid_in, gnt, drop, busy} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_ctl: valid=%b gnt=%b drop=%b busy=%b, want all 0", valid_in, gnt, drop, busy);
    end
    n_tests++;
    if ({data_in, addr_in} !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_bus: data=%h addr=%h, want 0", data_in, addr_in);
    end
  endtask

  task automatic test_single();
    do_reset();
    req_data[16 +: 16] = 16'hA5A5;
    req_addr[16 +: 16] = 16'h0003;
    req = 4'b0010; rcv_rdy = 4'hF;
    tick();
    n_tests++;
    if (valid_in !== 4'b0010 || data_in !== 16'hA5A5 || addr_in !== 16'h0003 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_drive: valid=%b data=%h addr=%h busy=%b, want 0010 A5A5 0003 1", valid_in, data_in, addr_in, busy);
    end
    tick();
    n_tests++;
    if (gnt !== 4'b0010 || valid_in !== 4'b0000 || busy !== 1'b0 || drop !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_gnt: gnt=%b valid=%b busy=%b drop=%b, want 0010 0000 0 0000", gnt, valid_in, busy, drop);
    end
    req = 4'b0000;
    tick();
    n_tests++;
    if (gnt !== 4'b0000 || valid_in !== 4'b0000 || data_in !== 16'hA5A5) begin
      n_fail++;
      $display("FAIL single_after: gnt=%b valid=%b data=%h, want 0000 0000 A5A5", gnt, valid_in, data_in);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0]  exp_oh;
    logic [15:0] exp_data;
    do_reset();
    req_data = 64'h1003_1002_1001_1000;
    req = 4'hF; rcv_rdy = 4'hF;
    for (int g = 0; g < 5; g++) begin
      exp_oh   = 4'b0001 << (g % 4);
      exp_data = 16'h1000 + 16'(g % 4);
      tick();
      n_tests++;
      if (valid_in !== exp_oh || data_in !== exp_data || gnt !== 4'b0000) begin
        n_fail++;
        $display("FAIL rr_drive%0d: valid=%b data=%h gnt=%b, want %b %h 0000", g, valid_in, data_in, gnt, exp_oh, exp_data);
      end
      tick();
      n_tests++;
      if (gnt !== exp_oh || valid_in !== 4'b0000) begin
        n_fail++;
        $display("FAIL rr_gnt%0d: gnt=%b valid=%b, want %b 0000", g, gnt, valid_in, exp_oh);
      end
    end
    req = 4'b0000;
  endtask

  task automatic test_backpressure();
    int vcycles = 0;
    do_reset();
    req_data[32 +: 16] = 16'h1234;
    req = 4'b0100; rcv_rdy = 4'b1011;
    tick();
    for (int i = 0; i < 10; i++) begin
      if (i == 5) req_data[32 +: 16] = 16'hDEAD;
      if (valid_in === 4'b0100 && data_in === 16'h1234 && gnt === 4'b0000 && drop === 4'b0000) vcycles++;
      tick();
    end
    if (valid_in === 4'b0100 && data_in === 16'h1234) vcycles++;
    n_tests++;
    if (vcycles != 11) begin
      n_fail++;
      $display("FAIL bp_hold: stable cycles=%0d, want 11", vcycles);
    end
    rcv_rdy = 4'b0100;
    tick();
    n_tests++;
    if (gnt !== 4'b0100 || drop !== 4'b0000 || valid_in !== 4'b0000) begin
      n_fail++;
      $display("FAIL bp_gnt: gnt=%b drop=%b valid=%b, want 0100 0000 0000", gnt, drop, valid_in);
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_timeout();
    int vcycles = 0;
    do_reset();
    req_data[0 +: 16]  = 16'h0F00;
    req_data[48 +: 16] = 16'h3333;
    req = 4'b1000; rcv_rdy = 4'b0000;
    tick();
    req = 4'b1001;
    for (int i = 0; i < 8; i++) begin
      if (t8_valid_in === 4'b1000 && t8_drop === 4'b0000 && t8_gnt === 4'b0000) vcycles++;
      tick();
    end
    n_tests++;
    if (vcycles != 8) begin
      n_fail++;
      $display("FAIL to_hold: valid cycles=%0d, want 8", vcycles);
    end
    n_tests++;
    if (t8_drop !== 4'b1000 || t8_gnt !== 4'b0000 || t8_valid_in !== 4'b0000) begin
      n_fail++;
      $display("FAIL to_drop: drop=%b gnt=%b valid=%b, want 1000 0000 0000", t8_drop, t8_gnt, t8_valid_in);
    end
    req = 4'b0001;
    tick();
    n_tests++;
    if (t8_valid_in !== 4'b0001 || t8_data_in !== 16'h0F00 || t8_drop !== 4'b0000) begin
      n_fail++;
      $display("FAIL to_next: valid=%b data=%h drop=%b, want 0001 0F00 0000", t8_valid_in, t8_data_in, t8_drop);
    end
    req = 4'b0000;
  endtask

  task automatic test_reset_mid_drive();
    do_reset();
    req_data = 64'h1003_1002_1001_1000;
    req = 4'b0010; rcv_rdy = 4'hF;
    tick();
    tick();
    req = 4'b0000;
    tick();
    req = 4'b0010; rcv_rdy = 4'b0000;
    tick();
    tick();
    n_tests++;
    if (valid_in !== 4'b0010) begin
      n_fail++;
      $display("FAIL rst_mid_setup: valid=%b, want 0010", valid_in);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_tests++;
    if (valid_in !== 4'b0000 || gnt !== 4'b0000 || drop !== 4'b0000 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid: valid=%b gnt=%b drop=%b busy=%b, want all 0", valid_in, gnt, drop, busy);
    end
    req = 4'b1010; rcv_rdy = 4'hF;
    tick();
    n_tests++;
    if (valid_in !== 4'b0010 || data_in !== 16'h1001) begin
      n_fail++;
      $display("FAIL rst_ptr: valid=%b data=%h, want 0010 1001", valid_in, data_in);
    end
    req = 4'b0000;
    tick();
  endtask

`ifdef SWITCH_ARB_GRANT_CNT_EN
  task automatic test_counters();
    int ngnt = 0;
    do_reset();
    req = 4'b0001; rcv_rdy = 4'hF;
    for (int c = 0; c < 100 && ngnt < 20; c++) begin
      tick();
      if (gnt[0] === 1'b1) ngnt++;
    end
    req = 4'b0000;
    tick();
    tick();
    n_tests++;
    if (ngnt != 20) begin
      n_fail++;
      $display("FAIL cnt_transfers: gnt pulses=%0d, want 20", ngnt);
    end
    n_tests++;
    if (grant_cnt !== 16'h000F || drop_cnt !== 16'h0000) begin
      n_fail++;
      $display("FAIL cnt_sat: grant_cnt=%h drop_cnt=%h, want 000F 0000", grant_cnt, drop_cnt);
    end
  endtask
`endif

  initial begin
    reset = 1'b1; req = 4'b0000; rcv_rdy = 4'b0000;
    req_data = 64'd0; req_addr = 64'd0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_reset_mid_drive();
`ifdef SWITCH_ARB_GRANT_CNT_EN
    test_counters();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/switch_ingress_arbiter.md
Name: switch_ingress_arbiter

Overview:
- Shares the single switch ingress bus (data_in/addr_in/valid_in) among four independent requesters, one per lane.
- Arbitrates round-robin, holds the winner's word on the bus until that lane's rcv_rdy, then returns a grant pulse.
- Stalled lanes are timed out so other requesters are not starved.
- Sits between the traffic sources and the 4-port switch's ingress side.

Parameters:
- DATA_W, 16, width of data_in and each requester data word.
- ADDR_W, 16, width of addr_in and each requester address word.
- TIMEOUT, 64, cycles to wait for rcv_rdy before dropping the word; 0 disables the timeout.
- CNT_W, 16, width of the optional grant counters.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- req  in  4  per-lane request; held high with req_data/req_addr stable until gnt or drop.
- req_data  in  4*DATA_W  lane i word at [i*DATA_W +: DATA_W].
- req_addr  in  4*ADDR_W  lane i address at [i*ADDR_W +: ADDR_W].
- gnt  out  4  one-cycle pulse: lane word accepted by the switch.
- drop  out  4  one-cycle pulse: lane word discarded on timeout.
- data_in  out  DATA_W  bus data to switch.
- addr_in  out  ADDR_W  bus address to switch.
- valid_in  out  4  one-hot, lane currently owning the bus; 0 when idle.
- rcv_rdy  in  4  per-lane switch ready.
- busy  out  1  high while in DRIVE.

Behaviour:
- Reset values: state IDLE; rr_ptr = 0; wait_cnt = 0; all outputs 0.
- All outputs are registered.
- State machine has two states, IDLE and DRIVE.
- IDLE:
  - eligible[i] = req[i] & ~gnt[i] & ~drop[i]. This masks a lane whose completion pulse is still high.
  - If any lane is eligible, pick the first eligible lane searching upward from rr_ptr, wrapping from 3 to 0.
  - On that edge: latch the winner's req_data/req_addr into data_in/addr_in, set valid_in = onehot(sel), wait_cnt = 0, go to DRIVE.
  - If no lane is eligible, stay in IDLE.
- DRIVE:
  - If rcv_rdy[sel] is sampled high: valid_in <= 0, gnt[sel] <= 1 for one cycle, rr_ptr <= sel+1 (mod 4), go to IDLE.
  - Else if TIMEOUT != 0 and wait_cnt == TIMEOUT-1: valid_in <= 0, drop[sel] <= 1 for one cycle, rr_ptr <= sel+1, go to IDLE.
  - Otherwise wait_cnt increments and valid_in/data_in/addr_in hold.
  - rcv_rdy on non-selected lanes is ignored.
  - Changes on req/req_data during DRIVE are ignored; the latched word stands, including when req drops mid-transfer.
- data_in/addr_in hold their last value when valid_in = 0.
- Latency:
  - req rises in cycle N while IDLE with no bubble → valid_in set in cycle N+1.
  - rcv_rdy already high → handshake at the edge ending N+1; gnt high in N+2.
  - Minimum 2 cycles per word because one IDLE cycle follows every completion.
- Simultaneous events:
  - rcv_rdy and timeout in the same cycle → accept; gnt wins, no drop.
- Reset asserted mid-DRIVE: the transfer is abandoned, no gnt/drop, and all state returns to reset values the next cycle.
- The wait_cnt width is clog2(TIMEOUT+1), minimum 1.

Optional Feature:
- Macro: SWITCH_ARB_GRANT_CNT_EN.
- Defined:
  - Adds output grant_cnt (4*CNT_W): per-lane saturating counters incremented on each gnt pulse.
  - Adds output drop_cnt (4*CNT_W): per-lane saturating counters incremented on each drop pulse.
  - Both are cleared by reset and hold at all-ones.
- Undefined: these ports and the counter logic are absent; all other behaviour is identical.

Decomposition:
- Package switch_arb_pkg holds:
  - NUM_LANES = 4.
  - typedef enum logic [0:0] {IDLE, DRIVE} arb_state_t.
  - lane_vec_t (logic [3:0]).
  - function onehot4.
- Sub-module rr_pick4 (combinational):
  - Inputs: eligible[3:0], ptr[1:0].
  - Outputs: sel[1:0], any.
  - Instantiated once.

Test Plan:
- Single request: req=4'b0010, req_data[1]=16'hA5A5, req_addr[1]=16'h0003, rcv_rdy=4'hF → valid_in=4'b0010 with data_in=A5A5/addr_in=0003 one cycle after req; gnt=4'b0010 the following cycle; busy low after.
- All four requesting continuously, rcv_rdy=4'hF, from reset → grant order lanes 0,1,2,3,0; one gnt every 2 cycles; no lane granted twice in a row.
- Backpressure: lane 2 only, rcv_rdy[2] held low 10 cycles then high → valid_in/data_in stable for 11 cycles, single gnt[2], no drop.
- Timeout with TIMEOUT=8: lane 3 requests, rcv_rdy=0 → valid_in=4'b1000 for exactly 8 cycles, then drop=4'b1000 pulse, gnt stays 0; pending lane 0 is served next.
- Reset mid-DRIVE: assert reset for 1 cycle while lane 1 is waiting → valid_in=0, gnt=0, drop=0 next cycle; first post-reset arbitration starts at lane 0.
- With SWITCH_ARB_GRANT_CNT_EN and CNT_W=4: 20 accepted transfers on lane 0 → grant_cnt lane 0 saturates at 4'hF; drop_cnt stays 0.
